circular_window_buffer: RTL and testbench

- Parametrised successor to the fixed 4-cell shift buffer used in the Chapter 9 pipeline/FIFO set.
- True circular buffer: a write pointer advances and stored data never moves.
- Adds write enable, synchronous flush, occupancy tracking, a selectable delay tap and a running window sum.
- Feeds moving-average and delay-line datapaths downstream of the pipeline stages.

---
 rtl/circular_window_buffer.sv | 76 +++++++
 tb/tb_circular_window_buffer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/circular_window_buffer.sv
// Circular delay-line buffer: a pointer advances over fixed cells, count masks stale
// data, and a running sum of the valid samples is kept for moving-average use.
module circular_window_buffer #(
    parameter int unsigned buff_size = 4,
    parameter int unsigned word_size = 8,
    parameter int unsigned addr_size = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [word_size-1:0]           Data_in,
    input  logic                           write_en,
    input  logic                           clear,
    input  logic [addr_size-1:0]           tap_sel,
    output logic [word_size-1:0]           tap_out,
    output logic [word_size-1:0]           newest,
    output logic [word_size-1:0]           oldest,
    output logic [addr_size:0]             count,
    output logic                           full,
    output logic [word_size+addr_size-1:0] window_sum
);

    localparam int unsigned cnt_w = addr_size + 1;
    localparam int unsigned sum_w = word_size + addr_size;

    logic [word_size-1:0] mem [buff_size];
    logic [addr_size-1:0] wr_ptr;
    logic [addr_size-1:0] tap_addr;
    logic [addr_size-1:0] new_addr;
    logic [addr_size-1:0] old_addr;
    logic                 accept;

    assign accept = write_en && !reset && !clear;
    assign full   = (count == cnt_w'(buff_size));

    // Cell k sits k writes behind the pointer; anything at or beyond count reads 0.
    always_comb begin
        tap_addr = wr_ptr - addr_size'(1) - tap_sel;
        new_addr = wr_ptr - addr_size'(1);
        old_addr = wr_ptr - addr_size'(count);
        tap_out  = '0;
        newest   = '0;
        oldest   = '0;
        if (cnt_w'(tap_sel) < count) begin
            tap_out = mem[tap_addr];
        end
        if (count != '0) begin
            newest = mem[new_addr];
            oldest = mem[old_addr];
        end
    end

    // Storage is never reset; count masking hides whatever it holds.
    always_ff @(posedge clock) begin
        if (accept) begin
            mem[wr_ptr] <= Data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_ptr     <= '0;
            count      <= '0;
            window_sum <= '0;
        end else if (write_en) begin
            wr_ptr <= wr_ptr + addr_size'(1);
            if (!full) begin
                count      <= count + cnt_w'(1);
                window_sum <= window_sum + sum_w'(Data_in);
            end else begin
                // Overwritten cell is the current oldest, so it leaves the window.
                window_sum <= window_sum + sum_w'(Data_in) - sum_w'(oldest);
            end
        end
    end

endmodule

// File: tb/tb_circular_window_buffer.sv
// Directed bench for circular_window_buffer with hand-computed expected values.
module tb_circular_window_buffer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  Data_in = '0;
    logic        write_en = 1'b0;
    logic        clear = 1'b0;
    logic [1:0]  tap_sel = '0;
    logic [7:0]  tap_out;
    logic [7:0]  newest;
    logic [7:0]  oldest;
    logic [2:0]  count;
    logic        full;
    logic [9:0]  window_sum;

    int n_vec = 0;
    int n_err = 0;

    circular_window_buffer #(.buff_size(4), .word_size(8), .addr_size(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .Data_in   (Data_in),
        .write_en  (write_en),
        .clear     (clear),
        .tap_sel   (tap_sel),
        .tap_out   (tap_out),
        .newest    (newest),
        .oldest    (oldest),
        .count     (count),
        .full      (full),
        .window_sum(window_sum)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one clock with the given controls, return at the following falling edge.
    task automatic cyc(input logic rst, input logic clr, input logic we, input logic [7:0] d);
        reset    = rst;
        clear    = clr;
        write_en = we;
        Data_in  = d;
        @(posedge clock);
        @(negedge clock);
        reset    = 1'b0;
        clear    = 1'b0;
        write_en = 1'b0;
    endtask

    task automatic chk_tap(input string tag, input int k, input logic [7:0] exp);
        tap_sel = 2'(k);
        #1;
        check(tag, 32'(tap_out), 32'(exp));
    endtask

    task automatic chk_state(input string tag, input logic [2:0] c, input logic f,
                             input logic [9:0] s, input logic [7:0] nw, input logic [7:0] od);
        check({tag, ".count"},  32'(count),      32'(c));
        check({tag, ".full"},   32'(full),       32'(f));
        check({tag, ".sum"},    32'(window_sum), 32'(s));
        check({tag, ".newest"}, 32'(newest),     32'(nw));
        check({tag, ".oldest"}, 32'(oldest),     32'(od));
    endtask

    initial begin
        logic [7:0] seq1 [3];
        seq1 = '{8'h11, 8'h22, 8'h33};
        @(negedge clock);

        // Reset wins even with write_en and clear asserted alongside.
        cyc(1'b1, 1'b1, 1'b1, 8'hAB);
        chk_state("rst", 3'd0, 1'b0, 10'h000, 8'h00, 8'h00);
        for (int k = 0; k < 4; k++) chk_tap("rst.tap", k, 8'h00);

        foreach (seq1[i]) cyc(1'b0, 1'b0, 1'b1, seq1[i]);
        chk_state("w3", 3'd3, 1'b0, 10'h066, 8'h33, 8'h11);
        chk_tap("w3.tap0", 0, 8'h33);
        chk_tap("w3.tap1", 1, 8'h22);
        chk_tap("w3.tap2", 2, 8'h11);
        chk_tap("w3.tap3", 3, 8'h00);

        cyc(1'b0, 1'b0, 1'b1, 8'h44);
        chk_state("w4", 3'd4, 1'b1, 10'h0AA, 8'h44, 8'h11);
        cyc(1'b0, 1'b0, 1'b1, 8'h55);
        chk_state("w5", 3'd4, 1'b1, 10'h0EE, 8'h55, 8'h22);
        chk_tap("w5.tap0", 0, 8'h55);
        chk_tap("w5.tap1", 1, 8'h44);
        chk_tap("w5.tap2", 2, 8'h33);
        chk_tap("w5.tap3", 3, 8'h22);

        // Idle cycles while full must not disturb anything.
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 8'hC3);
        chk_state("hold", 3'd4, 1'b1, 10'h0EE, 8'h55, 8'h22);
        chk_tap("hold.tap0", 0, 8'h55);
        chk_tap("hold.tap3", 3, 8'h22);

        // Clear beats a simultaneous write.
        cyc(1'b0, 1'b1, 1'b1, 8'h99);
        chk_state("clr", 3'd0, 1'b0, 10'h000, 8'h00, 8'h00);
        for (int k = 0; k < 4; k++) chk_tap("clr.tap", k, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 8'h07);
        chk_state("clr.w", 3'd1, 1'b0, 10'h007, 8'h07, 8'h07);
        chk_tap("clr.w.tap1", 1, 8'h00);

        // Maximum values: six writes of 0xFF wrap the pointer without overflowing the sum.
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b1, 8'hFF);
        chk_state("ff", 3'd4, 1'b1, 10'h3FC, 8'hFF, 8'hFF);
        for (int k = 0; k < 4; k++) chk_tap("ff.tap", k, 8'hFF);

        // Reset in the middle of a random stream; no stale samples may reappear.
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b1, 8'($urandom_range(1, 255)));
        cyc(1'b1, 1'b0, 1'b1, 8'hEE);
        chk_state("mid", 3'd0, 1'b0, 10'h000, 8'h00, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 8'h01);
        chk_state("mid.w", 3'd1, 1'b0, 10'h001, 8'h01, 8'h01);
        chk_tap("mid.tap0", 0, 8'h01);
        for (int k = 1; k < 4; k++) chk_tap("mid.tap", k, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
